// File: rtl/time_pkg.sv
// rtl/time_pkg.sv - shared constants, FSM state encoding and BCD codes for time_display
package time_pkg;

    localparam int SECS_W = 17;

    localparam logic [SECS_W-1:0] SECS_PER_DAY  = 17'd86400;
    localparam logic [SECS_W-1:0] SECS_PER_HOUR = 17'd3600;
    localparam logic [SECS_W-1:0] SECS_PER_MIN  = 17'd60;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SUB_H,
        ST_SUB_M,
        ST_SPL_H,
        ST_SPL_M,
        ST_SPL_S,
        ST_COMMIT
    } state_t;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_DASH  = 4'hA;
    localparam bcd_t BCD_BLANK = 4'hF;

endpackage

// File: rtl/time_display_if.sv
// rtl/time_display_if.sv - seconds input and multiplexed 7-segment display bundle
interface time_display_if;
    import time_pkg::*;

    logic [SECS_W-1:0] secs;
    logic [6:0]        seg;
    logic              dp;
    logic [7:0]        an;
    logic              busy;

    modport master (output secs, input seg, dp, an, busy);
    modport slave  (input secs, output seg, dp, an, busy);

endinterface

// File: rtl/bcd_to_seg.sv
// rtl/bcd_to_seg.sv - BCD digit to active-low {g,f,e,d,c,b,a} segment decoder
module bcd_to_seg
    import time_pkg::*;
(
    input  bcd_t       i_bcd,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = 7'h7F;
        case (i_bcd)
            4'h0:     o_seg = ~7'h3F;
            4'h1:     o_seg = ~7'h06;
            4'h2:     o_seg = ~7'h5B;
            4'h3:     o_seg = ~7'h4F;
            4'h4:     o_seg = ~7'h66;
            4'h5:     o_seg = ~7'h6D;
            4'h6:     o_seg = ~7'h7D;
            4'h7:     o_seg = ~7'h07;
            4'h8:     o_seg = ~7'h7F;
            4'h9:     o_seg = ~7'h6F;
            BCD_DASH: o_seg = ~7'h40;
            default:  o_seg = 7'h7F;
        endcase
    end

endmodule

// File: rtl/time_display.sv
// rtl/time_display.sv - seconds-of-day to HH:MM:SS converter with 8-digit multiplexed scan
module time_display
    import time_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int REFRESH_HZ = 1000
)
(
    input  logic           clk,
    input  logic           reset,
    time_display_if.slave  bus
);

    localparam int DWELL = (CLK_FREQ / REFRESH_HZ < 1) ? 1 : CLK_FREQ / REFRESH_HZ;
    localparam int DW_W  = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL - 1);

    state_t            r_state;
    state_t            w_next;
    logic [SECS_W-1:0] r_sample;
    logic [SECS_W-1:0] r_last;
    logic              r_first;
    logic              r_oor;
    logic [SECS_W-1:0] r_rem;
    logic [4:0]        r_h;
    logic [5:0]        r_m;
    logic [5:0]        r_s;
    bcd_t              r_ht;
    bcd_t              r_mt;
    bcd_t              r_st;
    bcd_t [5:0]        r_dig;

    logic [DW_W-1:0]   r_dwell;
    logic [2:0]        r_idx;
    logic [6:0]        r_seg;
    logic              r_dp;
    logic [7:0]        r_an;

    logic              w_start;
    logic              w_ge_h;
    logic              w_ge_m;
    bcd_t              w_digit;
    logic [7:0]        w_an;
    logic              w_dp;
    logic [6:0]        w_seg;

    assign w_start = r_first || (r_sample != r_last);
    assign w_ge_h  = (r_rem >= SECS_PER_HOUR);
    assign w_ge_m  = (r_rem >= SECS_PER_MIN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    // Every loop state leaves on the cycle its compare fails; out-of-range skips straight to COMMIT.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_start) w_next = ST_SUB_H;
            ST_SUB_H:  if (r_oor) w_next = ST_COMMIT;
                       else if (!w_ge_h) w_next = ST_SUB_M;
            ST_SUB_M:  if (!w_ge_m) w_next = ST_SPL_H;
            ST_SPL_H:  if (r_h < 5'd10) w_next = ST_SPL_M;
            ST_SPL_M:  if (r_m < 6'd10) w_next = ST_SPL_S;
            ST_SPL_S:  if (r_s < 6'd10) w_next = ST_COMMIT;
            ST_COMMIT: w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sample <= '0;
            r_last   <= '0;
            r_first  <= 1'b1;
            r_oor    <= 1'b0;
            r_rem    <= '0;
            r_h      <= '0;
            r_m      <= '0;
            r_s      <= '0;
            r_ht     <= '0;
            r_mt     <= '0;
            r_st     <= '0;
            r_dig    <= '0;
        end else begin
            r_sample <= bus.secs;
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_first <= 1'b0;
                        r_last  <= r_sample;
                        r_rem   <= r_sample;
                        r_oor   <= (r_sample >= SECS_PER_DAY);
                        r_h     <= '0;
                        r_m     <= '0;
                        r_s     <= '0;
                        r_ht    <= '0;
                        r_mt    <= '0;
                        r_st    <= '0;
                    end
                end
                ST_SUB_H: begin
                    if (!r_oor && w_ge_h) begin
                        r_rem <= r_rem - SECS_PER_HOUR;
                        r_h   <= r_h + 5'd1;
                    end
                end
                ST_SUB_M: begin
                    if (w_ge_m) begin
                        r_rem <= r_rem - SECS_PER_MIN;
                        r_m   <= r_m + 6'd1;
                    end else begin
                        r_s   <= r_rem[5:0];
                    end
                end
                ST_SPL_H: begin
                    if (r_h >= 5'd10) begin
                        r_h  <= r_h - 5'd10;
                        r_ht <= r_ht + 4'd1;
                    end
                end
                ST_SPL_M: begin
                    if (r_m >= 6'd10) begin
                        r_m  <= r_m - 6'd10;
                        r_mt <= r_mt + 4'd1;
                    end
                end
                ST_SPL_S: begin
                    if (r_s >= 6'd10) begin
                        r_s  <= r_s - 6'd10;
                        r_st <= r_st + 4'd1;
                    end
                end
                ST_COMMIT: begin
                    if (r_oor) r_dig <= {6{BCD_DASH}};
                    else       r_dig <= {r_ht, r_h[3:0], r_mt, r_m[3:0], r_st, r_s[3:0]};
                end
                default: ;
            endcase
        end
    end

    // Index 0..5 selects SL,SH,ML,MH,HL,HH; 6 and 7 are blank slots that keep the duty cycle even.
    always_comb begin
        w_digit = BCD_BLANK;
        w_an    = 8'hFF;
        case (r_idx)
            3'd0: begin w_digit = r_dig[0]; w_an = 8'hFE; end
            3'd1: begin w_digit = r_dig[1]; w_an = 8'hFD; end
            3'd2: begin w_digit = r_dig[2]; w_an = 8'hFB; end
            3'd3: begin w_digit = r_dig[3]; w_an = 8'hF7; end
            3'd4: begin w_digit = r_dig[4]; w_an = 8'hEF; end
            3'd5: begin w_digit = r_dig[5]; w_an = 8'hDF; end
            default: ;
        endcase
    end

    assign w_dp = !((r_idx == 3'd2) || (r_idx == 3'd4));

    bcd_to_seg u_bcd_to_seg (
        .i_bcd (w_digit),
        .o_seg (w_seg)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dwell <= '0;
            r_idx   <= '0;
            r_seg   <= 7'h7F;
            r_dp    <= 1'b1;
            r_an    <= 8'hFF;
        end else begin
            if (r_dwell == DWELL_LAST) begin
                r_dwell <= '0;
                r_idx   <= r_idx + 3'd1;
            end else begin
                r_dwell <= r_dwell + DW_W'(1);
            end
            r_seg <= w_seg;
            r_dp  <= w_dp;
            r_an  <= w_an;
        end
    end

    assign bus.seg  = r_seg;
    assign bus.dp   = r_dp;
    assign bus.an   = r_an;
    assign bus.busy = (r_state != ST_IDLE);

endmodule
